pipeline_ctrl: RTL and testbench

- Central stall/flush/sequencing controller for the 5-stage RV32 pipeline.
- Generates per-boundary advance enables that drive the valid/ready pairs of the F→D, D→E, E→M and M→W stage buffers.
- Tracks a per-stage instruction-valid (bubble) bit, resolves load-use hazards, fetch/memory wait, multi-cycle MDU ops, mispredict flush and ebreak halt.
- Sits beside the datapath; buffers keep stale contents in bubbles, and the v_* flags qualify them.

---
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush/sequencing controller for the 5-stage RV32 pipeline.
// Produces stage-buffer advance enables, per-stage valid bits, MDU handshake and perf counters.
//
// MDU FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   MDU_IDLE | no multi-cycle op outstanding
//   MDU_BUSY | MDU running, E-stage instruction held until mdu_done
//   MDU_DONE | result captured but M/W could not accept; release E when en_MW
module pipeline_ctrl #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_busy_F,
   input  logic             reg_ren_D,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             MemRead_E,
   input  logic [4:0]       Rd_E,
   input  logic             mispredict_E,
   input  logic             mdu_start_E,
   input  logic             mdu_done,
   input  logic             mem_busy_M,
   input  logic             ebreak_W,
   output logic             en_FD,
   output logic             en_DE,
   output logic             en_EM,
   output logic             en_MW,
   output logic             pc_en,
   output logic             redirect,
   output logic             mdu_go,
   output logic             v_D,
   output logic             v_E,
   output logic             v_M,
   output logic             v_W,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_t;

   mdu_state_t state, state_nxt;
   logic       run;
   logic       hold_M;
   logic       mdu_hold;
   logic       load_use;

   // Nothing may advance while reset is asserted or after an ebreak halt.
   assign run = ~rst & ~halted;

   always_comb begin
      hold_M   = v_M & mem_busy_M;
      mdu_hold = ((state == MDU_IDLE) & v_E & mdu_start_E)
               | ((state == MDU_BUSY) & ~mdu_done);
      load_use = v_D & v_E & MemRead_E & (Rd_E != 5'd0) & reg_ren_D
               & ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));
      en_MW    = run & ~hold_M;
      en_EM    = en_MW & ~mdu_hold;
      en_DE    = en_EM;
      en_FD    = en_DE & ~load_use;
      redirect = v_E & mispredict_E & en_EM;
      pc_en    = (en_FD & ~if_busy_F) | redirect;
   end

   always_comb begin
      state_nxt = state;
      mdu_go    = 1'b0;
      case (state)
         MDU_IDLE: begin
            if (v_E & mdu_start_E & run) begin
               state_nxt = MDU_BUSY;
               mdu_go    = 1'b1;
            end
         end
         MDU_BUSY: begin
            if (mdu_done)
               state_nxt = en_MW ? MDU_IDLE : MDU_DONE;
         end
         MDU_DONE: begin
            if (en_MW)
               state_nxt = MDU_IDLE;
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MDU_IDLE;
         v_D         <= 1'b0;
         v_E         <= 1'b0;
         v_M         <= 1'b0;
         v_W         <= 1'b0;
         halted      <= 1'b0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Valid bits and counters are frozen once halted.
         if (!halted) begin
            v_W       <= en_MW & v_M;
            v_M       <= en_EM ? v_E : (en_MW ? 1'b0 : v_M);
            v_E       <= en_DE ? (v_D & ~load_use & ~redirect) : v_E;
            v_D       <= redirect ? 1'b0 : (en_FD ? ~if_busy_F : v_D);
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (v_W)
               instret_cnt <= instret_cnt + CNT_W'(1);
            if (v_W & ebreak_W)
               halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected per-cycle output vectors are queued with
// the stimulus and popped when the cycle's outputs are sampled.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_busy_F, reg_ren_D, MemRead_E, mispredict_E;
   logic        mdu_start_E, mdu_done, mem_busy_M, ebreak_W;
   logic [4:0]  Rs1_D, Rs2_D, Rd_E;
   logic        en_FD, en_DE, en_EM, en_MW, pc_en, redirect, mdu_go;
   logic        v_D, v_E, v_M, v_W, halted;
   logic [63:0] cycle_cnt, instret_cnt;

   string       sb_tag[$];
   logic [11:0] sb_exp[$];
   int          checks = 0;
   int          errors = 0;

   pipeline_ctrl #(.CNT_W(64)) dut (
      .clk(clk), .rst(rst), .if_busy_F(if_busy_F), .reg_ren_D(reg_ren_D),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
      .mispredict_E(mispredict_E), .mdu_start_E(mdu_start_E), .mdu_done(mdu_done),
      .mem_busy_M(mem_busy_M), .ebreak_W(ebreak_W),
      .en_FD(en_FD), .en_DE(en_DE), .en_EM(en_EM), .en_MW(en_MW),
      .pc_en(pc_en), .redirect(redirect), .mdu_go(mdu_go),
      .v_D(v_D), .v_E(v_E), .v_M(v_M), .v_W(v_W), .halted(halted),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // {en_FD,en_DE,en_EM,en_MW, pc_en, redirect, mdu_go, v_D,v_E,v_M,v_W, halted}
   function automatic logic [11:0] obs();
      return {en_FD, en_DE, en_EM, en_MW, pc_en, redirect, mdu_go,
              v_D, v_E, v_M, v_W, halted};
   endfunction

   task automatic push(input string t, input logic [11:0] v);
      sb_tag.push_back(t);
      sb_exp.push_back(v);
   endtask

   task automatic clear_inputs();
      if_busy_F = 0; reg_ren_D = 0; MemRead_E = 0; mispredict_E = 0;
      mdu_start_E = 0; mdu_done = 0; mem_busy_M = 0; ebreak_W = 0;
      Rs1_D = 0; Rs2_D = 0; Rd_E = 0;
   endtask

   // Reset, then run four hazard-free cycles so every stage holds a valid instruction.
   task automatic fill();
      rst = 1;
      clear_inputs();
      @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      string tag; logic [11:0] want;
      rst = 1;
      clear_inputs();
      mdu_start_E = 1; mispredict_E = 1;
      push("reset_outputs", 12'b0000_0_0_0_0000_0);
      #2;
      tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
      if (obs() !== want) begin
         errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
      end
      checks++;
      if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
         errors++;
         $display("FAIL reset_counters: observed %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
      end
      @(negedge clk);
      clear_inputs();
      rst = 0;
   endtask

   task automatic test_fill();
      string tag; logic [11:0] want;
      push("fill_c0", 12'b1111_1_0_0_0000_0);
      push("fill_c1", 12'b1111_1_0_0_1000_0);
      push("fill_c2", 12'b1111_1_0_0_1100_0);
      push("fill_c3", 12'b1111_1_0_0_1110_0);
      push("fill_c4", 12'b1111_1_0_0_1111_0);
      push("fill_c5", 12'b1111_1_0_0_1111_0);
      for (int c = 0; c < 6; c++) begin
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (cycle_cnt !== 64'(c) || instret_cnt !== 64'(c - 4)) begin
               errors++;
               $display("FAIL fill_counters_c%0d: observed %0d/%0d expected %0d/%0d",
                        c, cycle_cnt, instret_cnt, c, c - 4);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load_use(input logic [4:0] rd);
      string tag; logic [11:0] want;
      fill();
      if (rd != 0) begin
         push("lu_stall",  12'b0111_0_0_0_1111_0);
         push("lu_bubble", 12'b1111_1_0_0_1011_0);
         push("lu_resume", 12'b1111_1_0_0_1101_0);
      end else begin
         push("lu_x0_c0", 12'b1111_1_0_0_1111_0);
         push("lu_x0_c1", 12'b1111_1_0_0_1111_0);
         push("lu_x0_c2", 12'b1111_1_0_0_1111_0);
      end
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         if (c == 0) begin
            MemRead_E = 1; Rd_E = rd; reg_ren_D = 1; Rs1_D = rd; Rs2_D = 5'd7;
         end
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mispredict();
      string tag; logic [11:0] want;
      fill();
      push("mp_redirect", 12'b1111_1_1_0_1111_0);
      push("mp_once",     12'b1111_1_0_0_0011_0);
      push("mp_refetch",  12'b1111_1_0_0_1001_0);
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         mispredict_E = (c < 2);
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mispredict_mem_busy();
      string tag; logic [11:0] want;
      fill();
      push("mpb_hold0",   12'b0000_0_0_0_1111_0);
      push("mpb_hold1",   12'b0000_0_0_0_1110_0);
      push("mpb_release", 12'b1111_1_1_0_1110_0);
      push("mpb_after",   12'b1111_1_0_0_0011_0);
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         mispredict_E = 1;
         mem_busy_M = (c < 2);
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lu_and_redirect();
      string tag; logic [11:0] want;
      fill();
      push("lur_same_cycle", 12'b0111_1_1_0_1111_0);
      push("lur_after",      12'b1111_1_0_0_0011_0);
      for (int c = 0; c < 2; c++) begin
         clear_inputs();
         if (c == 0) begin
            MemRead_E = 1; Rd_E = 5'd9; reg_ren_D = 1; Rs1_D = 5'd3; Rs2_D = 5'd9;
            mispredict_E = 1;
         end
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fetch_wait();
      string tag; logic [11:0] want;
      fill();
      push("fw_no_pc",  12'b1111_0_0_0_1111_0);
      push("fw_bubble", 12'b1111_0_0_0_0111_0);
      for (int c = 0; c < 2; c++) begin
         clear_inputs();
         if_busy_F = 1;
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mdu();
      string tag; logic [11:0] want;
      fill();
      push("mdu_go",        12'b0001_0_0_1_1111_0);
      push("mdu_busy1",     12'b0001_0_0_0_1101_0);
      push("mdu_busy2",     12'b0001_0_0_0_1100_0);
      push("mdu_busy3",     12'b0001_0_0_0_1100_0);
      push("mdu_done",      12'b1111_1_0_0_1100_0);
      push("mdu_stray_done",12'b1111_1_0_0_1110_0);
      push("mdu_after",     12'b1111_1_0_0_1111_0);
      for (int c = 0; c < 7; c++) begin
         clear_inputs();
         mdu_start_E = (c < 5);
         mdu_done = (c == 4 || c == 5);
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mdu_done_state();
      string tag; logic [11:0] want;
      fill();
      push("mdd_go",      12'b0000_0_0_1_1111_0);
      push("mdd_busy1",   12'b0000_0_0_0_1110_0);
      push("mdd_busy2",   12'b0000_0_0_0_1110_0);
      push("mdd_busy3",   12'b0000_0_0_0_1110_0);
      push("mdd_done_hi", 12'b0000_0_0_0_1110_0);
      push("mdd_wait",    12'b0000_0_0_0_1110_0);
      push("mdd_release", 12'b1111_1_0_0_1110_0);
      push("mdd_idle_go", 12'b0001_0_0_1_1111_0);
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         mdu_start_E = 1;
         mem_busy_M = (c < 6);
         mdu_done = (c == 4);
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_halt();
      string tag; logic [11:0] want;
      fill();
      push("halt_pre",  12'b1111_1_0_0_1111_0);
      push("halt_set",  12'b0000_0_0_0_1111_1);
      push("halt_hold", 12'b0000_0_0_0_1111_1);
      push("halt_hold2",12'b0000_0_0_0_1111_1);
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         ebreak_W = 1;
         if (c > 0) begin
            mispredict_E = 1; mdu_start_E = 1;
         end
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         if (c > 0) begin
            checks++;
            if (cycle_cnt !== 64'd5 || instret_cnt !== 64'd1) begin
               errors++;
               $display("FAIL halt_counters_c%0d: observed %0d/%0d expected 5/1",
                        c, cycle_cnt, instret_cnt);
            end
         end
         @(negedge clk);
      end
      // Asynchronous reset mid-halt, away from any clock edge.
      #1;
      rst = 1;
      push("halt_async_rst", 12'b0000_0_0_0_0000_0);
      #1;
      tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
      if (obs() !== want) begin
         errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
      end
      checks++;
      if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
         errors++;
         $display("FAIL halt_rst_counters: observed %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
      end
      @(negedge clk);
      rst = 0;
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_rst_mid_busy();
      string tag; logic [11:0] want;
      fill();
      push("rb_go",     12'b0001_0_0_1_1111_0);
      push("rb_busy",   12'b0001_0_0_0_1101_0);
      push("rb_rst",    12'b0000_0_0_0_0000_0);
      push("rb_idle",   12'b1111_1_0_0_0000_0);
      for (int c = 0; c < 2; c++) begin
         clear_inputs();
         mdu_start_E = 1;
         #2;
         tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
         if (obs() !== want) begin
            errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
         end
         if (c == 0) @(negedge clk);
      end
      // Still before the next rising edge: assert reset while the MDU FSM is BUSY.
      #1;
      rst = 1;
      #1;
      tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
      if (obs() !== want) begin
         errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
      end
      @(negedge clk);
      rst = 0;
      clear_inputs();
      #2;
      tag = sb_tag.pop_front(); want = sb_exp.pop_front(); checks++;
      if (obs() !== want) begin
         errors++; $display("FAIL %s: observed %b expected %b", tag, obs(), want);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_load_use(5'd5);
      test_load_use(5'd0);
      test_mispredict();
      test_mispredict_mem_busy();
      test_lu_and_redirect();
      test_fetch_wait();
      test_mdu();
      test_mdu_done_state();
      test_halt();
      test_rst_mid_busy();
      if (sb_exp.size() != 0) begin
         errors++; checks++;
         $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_exp.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
